// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode instruction queue, circular buffer with
//               first-word-fall-through head, flush and hold controls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int                XLEN  = 32,
  parameter int                ILEN  = 32,
  parameter int                DEPTH = 2,
  parameter logic [ILEN-1:0]   NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       hold_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            inst_addr_i,
  input  logic [ILEN-1:0]            inst_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            inst_addr_o,
  output logic [ILEN-1:0]            inst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    r_addr_mem [DEPTH];
  logic [ILEN-1:0]    r_inst_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_not_empty;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_not_empty = (r_count != '0);
  assign in_ready_o  = (r_count < c_CNT_W'(DEPTH)) & ~hold_i & ~flush_i;
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = w_not_empty & out_ready_i & ~hold_i & ~flush_i;

  assign out_valid_o = w_not_empty;
  assign inst_o      = w_not_empty ? r_inst_mem[r_rd_ptr] : NOP;
  assign inst_addr_o = w_not_empty ? r_addr_mem[r_rd_ptr] : '0;
  assign count_o     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; the head mux hides it whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= inst_addr_i;
      r_inst_mem[r_wr_ptr] <= inst_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Vector-table bench for if_id_queue (DEPTH=2) with a head
//               scoreboard and hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  localparam int                XLEN  = 32;
  localparam int                ILEN  = 32;
  localparam int                DEPTH = 2;
  localparam logic [ILEN-1:0]   NOP   = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_i = 1'b0;
  logic            hold_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [XLEN-1:0] inst_addr_i = '0;
  logic [ILEN-1:0] inst_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [XLEN-1:0] inst_addr_o;
  logic [ILEN-1:0] inst_o;
  logic [1:0]      count_o;

  if_id_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .hold_i      (hold_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_addr_i (inst_addr_i),
    .inst_i      (inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_addr_o (inst_addr_o),
    .inst_o      (inst_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        ho;
    logic        iv;
    logic        ordy;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        exp_rdy;
    int          exp_cnt;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fl, ho, iv, ordy, input logic [31:0] addr, inst,
                              input logic exp_rdy, input int exp_cnt, input string name);
    vec_t v;
    v.fl = fl; v.ho = ho; v.iv = iv; v.ordy = ordy; v.addr = addr; v.inst = inst;
    v.exp_rdy = exp_rdy; v.exp_cnt = exp_cnt; v.name = name;
    return v;
  endfunction

  // Checks the head against the scoreboard, then applies one clock edge.
  task automatic step(input vec_t v);
    logic do_push, do_pop;
    @(negedge clk);
    flush_i = v.fl; hold_i = v.ho; in_valid_i = v.iv; out_ready_i = v.ordy;
    inst_addr_i = v.addr; inst_i = v.inst;
    #1;
    chk({v.name, " in_ready"}, 64'(in_ready_o), 64'(v.exp_rdy));
    chk({v.name, " out_valid"}, 64'(out_valid_o), 64'(sb.size() != 0));
    if (sb.size() == 0) begin
      chk({v.name, " nop inst"}, 64'(inst_o), 64'(NOP));
      chk({v.name, " nop addr"}, 64'(inst_addr_o), 64'd0);
    end else begin
      chk({v.name, " head inst"}, 64'(inst_o), 64'(sb[0].inst));
      chk({v.name, " head addr"}, 64'(inst_addr_o), 64'(sb[0].addr));
    end
    do_pop  = v.ordy && !v.ho && !v.fl && (sb.size() != 0);
    do_push = v.iv && v.exp_rdy;
    @(posedge clk);
    #1;
    if (v.fl) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{addr: v.addr, inst: v.inst});
    end
    chk({v.name, " count"}, 64'(count_o), 64'(v.exp_cnt));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " out_valid"}, 64'(out_valid_o), 64'd0);
    chk({nm, " inst"}, 64'(inst_o), 64'(NOP));
    chk({nm, " addr"}, 64'(inst_addr_o), 64'd0);
    chk({nm, " count"}, 64'(count_o), 64'd0);
  endtask

  initial begin
    // fill and drain
    vecs.push_back(mk(0,0,1,0, 32'h0,  32'hAAAA0001, 1, 1, "fill_a"));
    vecs.push_back(mk(0,0,1,0, 32'h4,  32'hBBBB0002, 1, 2, "fill_b"));
    vecs.push_back(mk(0,0,1,0, 32'h8,  32'hDEAD0000, 0, 2, "full_reject"));
    vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        0, 1, "drain_a"));
    vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        1, 0, "drain_b"));
    vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        1, 0, "pop_empty"));
    // wrap-around, one entry in flight
    vecs.push_back(mk(0,0,1,1, 32'h0,  32'h11110000, 1, 1, "wrap0"));
    vecs.push_back(mk(0,0,1,1, 32'h4,  32'h11110001, 1, 1, "wrap1"));
    vecs.push_back(mk(0,0,1,1, 32'h8,  32'h11110002, 1, 1, "wrap2"));
    vecs.push_back(mk(0,0,1,1, 32'hC,  32'h11110003, 1, 1, "wrap3"));
    vecs.push_back(mk(0,0,1,1, 32'h10, 32'h11110004, 1, 1, "wrap4"));
    vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        1, 0, "wrap_drain"));
    // simultaneous push/pop
    vecs.push_back(mk(0,0,1,0, 32'h40, 32'hDDDD0000, 1, 1, "pp_load"));
    vecs.push_back(mk(0,0,1,1, 32'h44, 32'hCCCC0000, 1, 1, "pp_swap"));
    vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        1, 1, "pp_head_c"));
    // flush beats hold and drops the same-cycle push
    vecs.push_back(mk(0,0,1,0, 32'h48, 32'hEEEE0000, 1, 2, "fl_fill"));
    vecs.push_back(mk(1,1,1,1, 32'h4C, 32'hBAD00000, 0, 0, "flush"));
    vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,        1, 0, "post_flush"));
    // hold freezes everything
    vecs.push_back(mk(0,0,1,0, 32'h50, 32'hF0F00000, 1, 1, "hold_load"));
    vecs.push_back(mk(0,1,1,1, 32'h54, 32'hBAD00001, 0, 1, "hold1"));
    vecs.push_back(mk(0,1,1,1, 32'h58, 32'hBAD00002, 0, 1, "hold2"));
    vecs.push_back(mk(0,1,1,1, 32'h5C, 32'hBAD00003, 0, 1, "hold3"));
    vecs.push_back(mk(0,0,0,1, 32'h0,  32'h0,        1, 0, "hold_release"));

    // reset state
    #12;
    chk_reset_outputs("in_reset");
    chk("in_reset in_ready", 64'(in_ready_o), 64'd1);
    hold_i = 1'b1; #1;
    chk("in_reset in_ready hold", 64'(in_ready_o), 64'd0);
    hold_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // asynchronous reset with two entries stored
    step(mk(0,0,1,0, 32'h60, 32'h12340000, 1, 1, "ar_fill0"));
    step(mk(0,0,1,0, 32'h64, 32'h12340001, 1, 2, "ar_fill1"));
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    chk("async_rst in_ready", 64'(in_ready_o), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step(mk(0,0,1,0, 32'h20, 32'h77770000, 1, 1, "post_rst_push"));
    step(mk(0,0,0,1, 32'h0,  32'h0,        1, 0, "post_rst_pop"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
- REQ-001 SHALL have parameter XLEN, default 32: instruction-address width.
- REQ-002 SHALL have parameter ILEN, default 32: instruction width.
- REQ-003 SHALL have parameter DEPTH, default 2: entry count, legal range 1..16, any integer (not only powers of two).
- REQ-004 SHALL have parameter NOP, default 32'h00000013: instruction presented when no valid entry exists.
- REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
- REQ-007 SHALL have port flush_i, input, 1: discard all entries (branch/jump redirect).
- REQ-008 SHALL have port hold_i, input, 1: freeze all state (pipeline stall).
- REQ-009 SHALL have port in_valid_i, input, 1: fetch side offers an entry.
- REQ-010 SHALL have port in_ready_o, output, 1: queue accepts an entry this cycle.
- REQ-011 SHALL have port inst_addr_i, input, XLEN: fetched instruction address.
- REQ-012 SHALL have port inst_i, input, ILEN: fetched instruction.
- REQ-013 SHALL have port out_valid_o, output, 1: head entry valid toward decode.
- REQ-014 SHALL have port out_ready_i, input, 1: decode consumes the head.
- REQ-015 SHALL have port inst_addr_o, output, XLEN: head address.
- REQ-016 SHALL have port inst_o, output, ILEN: head instruction.
- REQ-017 SHALL have port count_o, output, $clog2(DEPTH+1): number of occupied entries.

Function
- REQ-018 SHALL be a circular buffer of DEPTH entries {addr, inst}, with read pointer, write pointer and count registers.
- REQ-019 SHALL compute in_ready_o = (count < DEPTH) & !hold_i & !flush_i, combinationally.
- REQ-020 SHALL push, when in_valid_i & in_ready_o, at the write pointer; the write pointer then advances, wrapping from DEPTH-1 to 0.
- REQ-021 SHALL compute out_valid_o = (count != 0), and SHALL NOT depend on hold_i.
- REQ-022 SHALL pop when out_valid_o & out_ready_i & !hold_i & !flush_i; the read pointer then advances with the same wrap rule.
- REQ-023 SHALL make head outputs first-word-fall-through: an entry pushed at edge N appears on inst_o/inst_addr_o after edge N (one-cycle latency) when the queue was empty.
- REQ-024 SHALL drive inst_o = NOP and inst_addr_o = 0 when count = 0, never stale storage.
- REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; at count = DEPTH a pop frees no slot for a same-cycle push, because in_ready_o is already 0.
- REQ-026 SHALL, when flush_i = 1, zero count and both pointers at the next edge, dropping any same-cycle push and pop; flush_i SHALL take priority over hold_i.
- REQ-027 SHALL, when hold_i = 1 and flush_i = 0, keep pointers, count and storage unchanged, with outputs stable.
- REQ-028 SHALL keep count within 0..DEPTH; a pop request at count 0 is a no-op.

Reset
- REQ-029 SHALL, while rst = 1 (asynchronous, immediate), clear count, read pointer and write pointer to 0.
- REQ-030 SHALL, during reset, drive out_valid_o = 0, inst_o = NOP, inst_addr_o = 0, count_o = 0, and in_ready_o = !hold_i & !flush_i.
- REQ-031 SHALL NOT reset storage contents; they are unobservable while count = 0.
- REQ-032 SHALL let a reset asserted mid-operation discard all entries; the first push after release SHALL behave as a push into an empty queue.

Verification (DEPTH=2)
- REQ-033 Bench SHALL cover fill and drain: push (0x0,A),(0x4,B) with out_ready_i = 0 -> count_o = 2, in_ready_o = 0, head = (0x0,A); then out_ready_i = 1 for two cycles -> outputs B, then NOP with out_valid_o = 0.
- REQ-034 Bench SHALL cover wrap-around: push/pop 5 entries one at a time -> order preserved, addresses 0x0..0x10 in sequence, pointers wrap, count never exceeds 1.
- REQ-035 Bench SHALL cover simultaneous push/pop: count = 1, push C while popping -> count stays 1, head becomes C next cycle.
- REQ-036 Bench SHALL cover flush priority: count = 2, flush_i = 1 with hold_i = 1 and in_valid_i = 1 -> next cycle count_o = 0, inst_o = NOP, the pushed entry is absent.
- REQ-037 Bench SHALL cover hold: count = 1, hold_i = 1 for 3 cycles with in_valid_i = out_ready_i = 1 -> no state change, in_ready_o = 0, head stable.
- REQ-038 Bench SHALL cover asynchronous reset: assert rst between edges with count = 2 -> outputs go to the reset values without waiting for a clock edge.
